clint_vec: RTL and testbench



---
 rtl/clint_vec.sv | 228 ++++++++++++++++++++++
 tb/tb_clint_vec.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/clint_vec.sv
// clint_vec -- core-local interrupt controller for the RV32 core.
//
// Arbitrates ecall/ebreak, INT_NUM level-sensitive external sources (fixed
// priority, lowest index wins, per-source mie mask, global mstatus.MIE) and
// mret. Sequences the mepc/mstatus/mcause CSR writes, stalls the pipeline
// while busy and redirects execution with a one-cycle pulse.
//
// Optional feature macro: CLINT_VECTORED_EN
//   When defined and mtvec[1:0]==2'b01, asynchronous traps jump to
//   base + 4*(16+src). Otherwise every trap jumps to the mtvec base.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   int_req_i           level interrupt requests (bit i = source i)
//   csr_mie_i           per-source enable mask
//   inst_valid_i        inst_i/inst_addr_i carry a real instruction
//   inst_i, inst_addr_i instruction in decode and its PC
//   jump_flag_i/addr_i  ex redirect this cycle and its target
//   csr_mtvec_i, csr_mepc_i, csr_mstatus_i   current CSR values
//   hold_flag_o         pipeline stall request
//   we_o, waddr_o, data_o   CSR write port
//   int_assert_o, int_addr_o   one-cycle redirect pulse and target
//   int_ack_o           one-hot acknowledge of the taken source
module clint_vec #(
  parameter int INT_NUM        = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INT_NUM-1:0]        int_req_i,
  input  logic [INT_NUM-1:0]        csr_mie_i,
  input  logic                      inst_valid_i,
  input  logic [31:0]               inst_i,
  input  logic [DATA_WIDTH-1:0]     inst_addr_i,
  input  logic                      jump_flag_i,
  input  logic [DATA_WIDTH-1:0]     jump_addr_i,
  input  logic [DATA_WIDTH-1:0]     csr_mtvec_i,
  input  logic [DATA_WIDTH-1:0]     csr_mepc_i,
  input  logic [DATA_WIDTH-1:0]     csr_mstatus_i,
  output logic                      hold_flag_o,
  output logic                      we_o,
  output logic [CSR_ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      int_assert_o,
  output logic [DATA_WIDTH-1:0]     int_addr_o,
  output logic [INT_NUM-1:0]        int_ack_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);

  typedef enum logic [2:0] {
    S_IDLE, S_W_MEPC, S_W_MSTATUS, S_W_MCAUSE, S_W_MRET, S_ASSERT
  } state_t;

  typedef enum logic [1:0] {D_NONE, D_SYNC, D_ASYNC, D_MRET} decision_t;

  state_t                  state;
  decision_t               decision;
  logic [INT_NUM-1:0]      pending;
  logic [3:0]              pend_idx;
  logic                    pend_any;
  logic [DATA_WIDTH-1:0]   sync_epc;
  logic [DATA_WIDTH-1:0]   async_epc;
  logic [DATA_WIDTH-1:0]   mstatus_trap;
  logic [DATA_WIDTH-1:0]   mstatus_mret;
  logic [DATA_WIDTH-1:0]   trap_base;
  logic [DATA_WIDTH-1:0]   trap_target;
  logic [DATA_WIDTH-1:0]   epc_q;
  logic [31:0]             cause_q;
  logic [3:0]              src_q;
  logic                    async_q;

  assign pending = int_req_i & csr_mie_i;

  // Lowest-index pending source wins: scanning downward lets the lowest
  // set bit overwrite any higher one.
  always_comb begin
    pend_idx = '0;
    pend_any = 1'b0;
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pend_idx = 4'(i);
        pend_any = 1'b1;
      end
    end
  end

  // Synchronous exceptions beat interrupts, which beat mret.
  always_comb begin
    decision = D_NONE;
    if (state == S_IDLE && inst_valid_i) begin
      if (inst_i == INST_ECALL || inst_i == INST_EBREAK)
        decision = D_SYNC;
      else if (pend_any && csr_mstatus_i[3])
        decision = D_ASYNC;
      else if (inst_i == INST_MRET)
        decision = D_MRET;
    end
  end

  assign hold_flag_o = (state != S_IDLE) || (decision != D_NONE);

  // When ex is redirecting, a synchronous trap belongs to the instruction
  // just before the jump target; an interrupt resumes at the target itself.
  assign sync_epc  = jump_flag_i ? (jump_addr_i - DATA_WIDTH'(4)) : inst_addr_i;
  assign async_epc = jump_flag_i ? jump_addr_i : inst_addr_i;

  always_comb begin
    mstatus_trap    = csr_mstatus_i;
    mstatus_trap[7] = csr_mstatus_i[3];
    mstatus_trap[3] = 1'b0;
    mstatus_mret    = csr_mstatus_i;
    mstatus_mret[3] = csr_mstatus_i[7];
    mstatus_mret[7] = 1'b1;
  end

  assign trap_base = {csr_mtvec_i[DATA_WIDTH-1:2], 2'b00};

`ifdef CLINT_VECTORED_EN
  always_comb begin
    if (async_q && csr_mtvec_i[1:0] == 2'b01)
      trap_target = trap_base + DATA_WIDTH'((32'd16 + 32'(src_q)) << 2);
    else
      trap_target = trap_base;
  end
`else
  logic unused_mode;
  assign unused_mode = ^{csr_mtvec_i[1:0], async_q};
  assign trap_target = trap_base;
`endif

  // Outputs are registered alongside the state: each transition loads the
  // values that belong to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      src_q        <= '0;
      async_q      <= 1'b0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
      int_ack_o    <= '0;
    end else begin
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
      int_ack_o    <= '0;
      unique case (state)
        S_IDLE: begin
          unique case (decision)
            D_SYNC: begin
              state   <= S_W_MEPC;
              epc_q   <= sync_epc;
              cause_q <= (inst_i == INST_ECALL) ? 32'd11 : 32'd3;
              src_q   <= '0;
              async_q <= 1'b0;
              we_o    <= 1'b1;
              waddr_o <= ADDR_MEPC;
              data_o  <= sync_epc;
            end
            D_ASYNC: begin
              state   <= S_W_MEPC;
              epc_q   <= async_epc;
              cause_q <= 32'h8000_0000 | (32'd16 + 32'(pend_idx));
              src_q   <= pend_idx;
              async_q <= 1'b1;
              we_o    <= 1'b1;
              waddr_o <= ADDR_MEPC;
              data_o  <= async_epc;
            end
            D_MRET: begin
              state   <= S_W_MRET;
              async_q <= 1'b0;
              we_o    <= 1'b1;
              waddr_o <= ADDR_MSTATUS;
              data_o  <= mstatus_mret;
            end
            default: state <= S_IDLE;
          endcase
        end
        S_W_MEPC: begin
          state   <= S_W_MSTATUS;
          we_o    <= 1'b1;
          waddr_o <= ADDR_MSTATUS;
          data_o  <= mstatus_trap;
        end
        S_W_MSTATUS: begin
          state   <= S_W_MCAUSE;
          we_o    <= 1'b1;
          waddr_o <= ADDR_MCAUSE;
          data_o  <= DATA_WIDTH'(cause_q);
        end
        S_W_MCAUSE: begin
          state        <= S_ASSERT;
          int_assert_o <= 1'b1;
          int_addr_o   <= trap_target;
          if (async_q)
            int_ack_o <= INT_NUM'(1) << src_q;
        end
        S_W_MRET: begin
          state        <= S_ASSERT;
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_mepc_i;
        end
        S_ASSERT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Unused upper epc bits are kept for debug visibility of the latched PC.
  logic unused_epc;
  assign unused_epc = ^epc_q;

endmodule

// File: tb/tb_clint_vec.sv
// tb_clint_vec -- directed self-checking bench for clint_vec.
// Inputs change #1 after the rising edge; outputs are checked one step later.
module tb_clint_vec;

  localparam int INT_NUM = 8;
  localparam int DW      = 32;
  localparam int AW      = 32;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

`ifdef CLINT_VECTORED_EN
  localparam logic [31:0] VEC_SRC1_ADDR = 32'h0000_0244;
`else
  localparam logic [31:0] VEC_SRC1_ADDR = 32'h0000_0200;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [INT_NUM-1:0] int_req;
  logic [INT_NUM-1:0] csr_mie;
  logic               inst_valid;
  logic [31:0]        inst;
  logic [DW-1:0]      inst_addr;
  logic               jump_flag;
  logic [DW-1:0]      jump_addr;
  logic [DW-1:0]      csr_mtvec;
  logic [DW-1:0]      csr_mepc;
  logic [DW-1:0]      csr_mstatus;
  logic               hold_flag;
  logic               we;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      data;
  logic               int_assert;
  logic [DW-1:0]      int_addr;
  logic [INT_NUM-1:0] int_ack;

  int vectors     = 0;
  int miscompares = 0;

  clint_vec #(.INT_NUM(INT_NUM), .DATA_WIDTH(DW), .CSR_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .int_req_i(int_req), .csr_mie_i(csr_mie),
    .inst_valid_i(inst_valid), .inst_i(inst), .inst_addr_i(inst_addr),
    .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .csr_mtvec_i(csr_mtvec), .csr_mepc_i(csr_mepc), .csr_mstatus_i(csr_mstatus),
    .hold_flag_o(hold_flag), .we_o(we), .waddr_o(waddr), .data_o(data),
    .int_assert_o(int_assert), .int_addr_o(int_addr), .int_ack_o(int_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive the decode-side inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic valid, input logic [31:0] ins,
                               input logic [31:0] pc, input logic jf,
                               input logic [31:0] ja);
    inst_valid = valid;
    inst       = ins;
    inst_addr  = pc;
    jump_flag  = jf;
    jump_addr  = ja;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Full trap sequence from decision (cycle 0) to return to IDLE (cycle 5).
  task automatic runTrap(input string name, input logic [31:0] ins,
                         input logic [31:0] pc, input logic jf, input logic [31:0] ja,
                         input logic [31:0] exp_epc, input logic [31:0] exp_mstatus,
                         input logic [31:0] exp_cause, input logic [31:0] exp_addr,
                         input logic [31:0] exp_ack);
    applyStimulus(1'b1, ins, pc, jf, ja);
    checkOutput({name, ".c0.hold"}, 32'(hold_flag), 32'd1);
    checkOutput({name, ".c0.we"}, 32'(we), 32'd0);
    nextCycle();
    applyStimulus(1'b0, NOP, 32'h0, 1'b0, 32'h0);
    checkOutput({name, ".c1.we"}, 32'(we), 32'd1);
    checkOutput({name, ".c1.waddr"}, waddr, 32'h341);
    checkOutput({name, ".c1.mepc"}, data, exp_epc);
    checkOutput({name, ".c1.hold"}, 32'(hold_flag), 32'd1);
    nextCycle();
    checkOutput({name, ".c2.waddr"}, waddr, 32'h300);
    checkOutput({name, ".c2.mstatus"}, data, exp_mstatus);
    nextCycle();
    checkOutput({name, ".c3.waddr"}, waddr, 32'h342);
    checkOutput({name, ".c3.mcause"}, data, exp_cause);
    nextCycle();
    checkOutput({name, ".c4.we"}, 32'(we), 32'd0);
    checkOutput({name, ".c4.assert"}, 32'(int_assert), 32'd1);
    checkOutput({name, ".c4.addr"}, int_addr, exp_addr);
    checkOutput({name, ".c4.ack"}, 32'(int_ack), exp_ack);
    checkOutput({name, ".c4.hold"}, 32'(hold_flag), 32'd1);
    nextCycle();
    checkOutput({name, ".c5.assert"}, 32'(int_assert), 32'd0);
    checkOutput({name, ".c5.addr"}, int_addr, 32'd0);
    checkOutput({name, ".c5.hold"}, 32'(hold_flag), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    int_req     = '0;
    csr_mie     = 8'hFF;
    csr_mtvec   = 32'h200;
    csr_mepc    = 32'h0;
    csr_mstatus = 32'h8;
    applyStimulus(1'b0, NOP, 32'h0, 1'b0, 32'h0);
    repeat (2) nextCycle();
    $display("[TB] reset state");
    checkOutput("rst.hold", 32'(hold_flag), 32'd0);
    checkOutput("rst.we", 32'(we), 32'd0);
    checkOutput("rst.waddr", waddr, 32'd0);
    checkOutput("rst.data", data, 32'd0);
    checkOutput("rst.assert", 32'(int_assert), 32'd0);
    checkOutput("rst.addr", int_addr, 32'd0);
    checkOutput("rst.ack", 32'(int_ack), 32'd0);
    rst_n = 1'b1;
    nextCycle();

    $display("[TB] ecall at 0x100");
    runTrap("ecall", ECALL, 32'h100, 1'b0, 32'h0, 32'h100, 32'h80, 32'd11, 32'h200, 32'h0);

    $display("[TB] async sources 2,3 pending");
    int_req = 8'h0C;
    runTrap("async", NOP, 32'h40, 1'b0, 32'h0, 32'h40, 32'h80, 32'h8000_0012, 32'h200, 32'h04);
    runTrap("async_jmp", NOP, 32'h40, 1'b1, 32'h80, 32'h80, 32'h80, 32'h8000_0012, 32'h200, 32'h04);
    int_req = '0;

    $display("[TB] ecall/ebreak with redirect");
    runTrap("ecall_jmp", ECALL, 32'h40, 1'b1, 32'h80, 32'h7C, 32'h80, 32'd11, 32'h200, 32'h0);
    csr_mstatus = 32'h88;
    runTrap("ebreak", EBREAK, 32'h104, 1'b0, 32'h0, 32'h104, 32'h80, 32'd3, 32'h200, 32'h0);
    csr_mstatus = 32'h8;

    $display("[TB] ecall beats pending source 0");
    int_req = 8'h01;
    runTrap("sync_wins", ECALL, 32'h60, 1'b0, 32'h0, 32'h60, 32'h80, 32'd11, 32'h200, 32'h0);
    int_req = '0;

    $display("[TB] mret");
    csr_mstatus = 32'h80;
    csr_mepc    = 32'h44;
    applyStimulus(1'b1, MRET, 32'h300, 1'b0, 32'h0);
    checkOutput("mret.c0.hold", 32'(hold_flag), 32'd1);
    nextCycle();
    applyStimulus(1'b0, NOP, 32'h0, 1'b0, 32'h0);
    checkOutput("mret.c1.we", 32'(we), 32'd1);
    checkOutput("mret.c1.waddr", waddr, 32'h300);
    checkOutput("mret.c1.mstatus", data, 32'h88);
    nextCycle();
    checkOutput("mret.c2.assert", 32'(int_assert), 32'd1);
    checkOutput("mret.c2.addr", int_addr, 32'h44);
    checkOutput("mret.c2.ack", 32'(int_ack), 32'd0);
    nextCycle();
    checkOutput("mret.c3.assert", 32'(int_assert), 32'd0);
    checkOutput("mret.c3.hold", 32'(hold_flag), 32'd0);

    $display("[TB] mtvec mode 01");
    csr_mstatus = 32'h8;
    csr_mtvec   = 32'h201;
    int_req     = 8'h02;
    runTrap("vec_src1", NOP, 32'h50, 1'b0, 32'h0, 32'h50, 32'h80, 32'h8000_0011, VEC_SRC1_ADDR, 32'h02);
    int_req = '0;
    runTrap("vec_ecall", ECALL, 32'h54, 1'b0, 32'h0, 32'h54, 32'h80, 32'd11, 32'h200, 32'h0);
    csr_mtvec = 32'h200;

    $display("[TB] masked requests");
    int_req = 8'h02;
    csr_mie = 8'hFD;
    applyStimulus(1'b1, NOP, 32'h58, 1'b0, 32'h0);
    checkOutput("mie_masked.hold", 32'(hold_flag), 32'd0);
    nextCycle();
    checkOutput("mie_masked.we", 32'(we), 32'd0);
    csr_mie     = 8'hFF;
    csr_mstatus = 32'h0;
    applyStimulus(1'b1, NOP, 32'h5C, 1'b0, 32'h0);
    checkOutput("mie_off.hold", 32'(hold_flag), 32'd0);
    nextCycle();
    checkOutput("mie_off.we", 32'(we), 32'd0);
    applyStimulus(1'b0, NOP, 32'h0, 1'b0, 32'h0);
    int_req     = '0;
    csr_mstatus = 32'h8;

    $display("[TB] reset during mstatus write");
    applyStimulus(1'b1, ECALL, 32'h100, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, NOP, 32'h0, 1'b0, 32'h0);
    nextCycle();
    checkOutput("midrst.pre.waddr", waddr, 32'h300);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.we", 32'(we), 32'd0);
    checkOutput("midrst.waddr", waddr, 32'd0);
    checkOutput("midrst.data", data, 32'd0);
    checkOutput("midrst.hold", 32'(hold_flag), 32'd0);
    nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      checkOutput($sformatf("postrst.c%0d.we", i), 32'(we), 32'd0);
      checkOutput($sformatf("postrst.c%0d.assert", i), 32'(int_assert), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
